// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte buffer between the UART receiver and the
// APB RX data register. First-word-fall-through head, registered occupancy
// count, and a sticky overflow flag for the status register.
//
// Build option: define UART_RX_FIFO_IRQ_EN to add the level/overflow
// interrupt (parameter IRQ_LVL, input irq_en, output irq).
//
// Handshake: there is no back-pressure on either side.
//   - A push is taken when wr_valid=1 and there is room. Room means full=0,
//     or full=1 with rd_req=1 in the same cycle.
//   - A push with wr_valid=1, full=1 and rd_req=0 is dropped and sets the
//     overflow flag.
//   - A pop is taken when rd_req=1 and empty=0.
//   - rd_data is valid in the same cycle rd_req is asserted.
module uart_rx_fifo #(
  parameter int UART_WIDTH = 8,
  parameter int DEPTH      = 16,
`ifdef UART_RX_FIFO_IRQ_EN
  parameter int IRQ_LVL    = DEPTH / 2,
`endif
  localparam int CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic [UART_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  input  logic                  rd_req,
  input  logic                  flush,
  input  logic                  clr_ovf,
`ifdef UART_RX_FIFO_IRQ_EN
  input  logic                  irq_en,
`endif
  output logic [UART_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [CNT_W-1:0]      count,
  output logic                  overflow
`ifdef UART_RX_FIFO_IRQ_EN
  ,
  output logic                  irq
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [UART_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wp;
  logic [AW-1:0]         rp;
  logic                  push_ok;
  logic                  pop_ok;
  logic                  drop;
  logic [CNT_W-1:0]      count_next;
  logic                  overflow_next;

  // Status flags are decoded directly from the registered count.
  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  // The head is driven only from registered state, so there is no
  // combinational path from wr_valid to any output.
  assign rd_data = empty ? '0 : mem[rp];

  // Acceptance decode and next-state of count and overflow.
  // A full FIFO with a simultaneous pop frees the head slot in this cycle,
  // so the push is taken into that slot.
  always_comb begin
    pop_ok        = rd_req & ~empty;
    push_ok       = wr_valid & (~full | rd_req);
    drop          = wr_valid & full & ~rd_req;
    count_next    = count;
    overflow_next = overflow;
    if (flush) begin
      count_next = '0;
    end else begin
      unique case ({push_ok, pop_ok})
        2'b10:   count_next = count + CNT_W'(1);
        2'b01:   count_next = count - CNT_W'(1);
        default: count_next = count;
      endcase
    end
    // A new drop beats a clear in the same cycle. Flush leaves the flag alone.
    if (drop && !flush) begin
      overflow_next = 1'b1;
    end else if (clr_ovf) begin
      overflow_next = 1'b0;
    end
  end

  // Pointer, count and overflow registers. Priority is reset, then flush,
  // then push/pop.
  always_ff @(posedge clk) begin
    if (!arstn) begin
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      count    <= count_next;
      overflow <= overflow_next;
      if (flush) begin
        wp <= '0;
        rp <= '0;
      end else begin
        if (push_ok) wp <= wp + AW'(1);
        if (pop_ok)  rp <= rp + AW'(1);
      end
    end
  end

  // Storage write. The array itself is not reset.
  always_ff @(posedge clk) begin
    if (arstn && !flush && push_ok) begin
      mem[wp] <= wr_data;
    end
  end

`ifdef UART_RX_FIFO_IRQ_EN
  localparam logic [CNT_W-1:0] IRQ_CNT = CNT_W'(IRQ_LVL);

  // The interrupt is computed from the same next-state values as count, so
  // it asserts in the same cycle the count reaches the threshold.
  always_ff @(posedge clk) begin
    if (!arstn) begin
      irq <= 1'b0;
    end else begin
      irq <= irq_en & ((count_next >= IRQ_CNT) | overflow_next);
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: table-driven vectors, hand-written corner sequences and
// randomized traffic for uart_rx_fifo. The reference model is a byte queue
// plus an overflow bit.
module tb_uart_rx_fifo;

  localparam int W     = 8;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef UART_RX_FIFO_IRQ_EN
  localparam int LVL   = 8;
`endif

  logic          clk;
  logic          arstn;
  logic [W-1:0]  wr_data;
  logic          wr_valid;
  logic          rd_req;
  logic          flush;
  logic          clr_ovf;
  logic [W-1:0]  rd_data;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic          overflow;
`ifdef UART_RX_FIFO_IRQ_EN
  logic          irq_en;
  logic          irq;
`endif

  uart_rx_fifo #(
    .UART_WIDTH(W),
    .DEPTH(DEPTH)
`ifdef UART_RX_FIFO_IRQ_EN
    ,
    .IRQ_LVL(LVL)
`endif
  ) dut (
    .clk(clk),
    .arstn(arstn),
    .wr_data(wr_data),
    .wr_valid(wr_valid),
    .rd_req(rd_req),
    .flush(flush),
    .clr_ovf(clr_ovf),
`ifdef UART_RX_FIFO_IRQ_EN
    .irq_en(irq_en),
`endif
    .rd_data(rd_data),
    .empty(empty),
    .full(full),
    .count(count),
    .overflow(overflow)
`ifdef UART_RX_FIFO_IRQ_EN
    ,
    .irq(irq)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic         ovf_m;
  logic         irq_m;
  int           total;
  int           bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: apply one clock of inputs to the queue.
  task automatic model_step(input logic wv, input logic [W-1:0] wd, input logic rr,
                            input logic fl, input logic co, input logic ie);
    bit was_full;
    was_full = (exp_q.size() == DEPTH);
    if (fl) begin
      exp_q.delete();
      if (co) ovf_m = 1'b0;
    end else begin
      if (rr && exp_q.size() > 0) void'(exp_q.pop_front());
      if (wv && (!was_full || rr)) exp_q.push_back(wd);
      if (wv && was_full && !rr) ovf_m = 1'b1;
      else if (co) ovf_m = 1'b0;
    end
    irq_m = ie & ((exp_q.size() >= DEPTH / 2) | ovf_m);
  endtask

  task automatic check_model(input string tag);
    logic [W-1:0] head;
    head = (exp_q.size() > 0) ? exp_q[0] : '0;
    chk({tag, "_count"}, 32'(count), 32'(exp_q.size()));
    chk({tag, "_empty"}, 32'(empty), 32'(exp_q.size() == 0));
    chk({tag, "_full"},  32'(full),  32'(exp_q.size() == DEPTH));
    chk({tag, "_ovf"},   32'(overflow), 32'(ovf_m));
    chk({tag, "_data"},  32'(rd_data), 32'(head));
`ifdef UART_RX_FIFO_IRQ_EN
    chk({tag, "_irq"},   32'(irq), 32'(irq_m));
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    arstn = 1'b0; wr_valid = 1'b0; wr_data = '0; rd_req = 1'b0;
    flush = 1'b0; clr_ovf = 1'b0;
`ifdef UART_RX_FIFO_IRQ_EN
    irq_en = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    arstn = 1'b1;
    exp_q.delete();
    ovf_m = 1'b0;
    irq_m = 1'b0;
  endtask

  task automatic cycle(input logic wv, input logic [W-1:0] wd, input logic rr,
                       input logic fl, input logic co, input string tag);
    logic ie;
    ie = 1'b0;
`ifdef UART_RX_FIFO_IRQ_EN
    ie = irq_en;
`endif
    wr_valid = wv; wr_data = wd; rd_req = rr; flush = fl; clr_ovf = co;
    @(posedge clk);
    model_step(wv, wd, rr, fl, co, ie);
    #1;
    wr_valid = 1'b0; rd_req = 1'b0; flush = 1'b0; clr_ovf = 1'b0;
    check_model(tag);
  endtask

  task automatic push(input logic [W-1:0] d, input string tag);
    cycle(1'b1, d, 1'b0, 1'b0, 1'b0, tag);
  endtask

  task automatic pop_expect(input logic [W-1:0] d, input string tag);
    chk({tag, "_head"}, 32'(rd_data), 32'(d));
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, tag);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          wv;
    logic [W-1:0]  wd;
    logic          rr;
    logic          fl;
    logic          co;
    logic [CW-1:0] e_count;
    logic          e_empty;
    logic          e_full;
    logic          e_ovf;
    logic [W-1:0]  e_data;
  } vec_t;

  vec_t vecs[8];

  initial begin
    total = 0;
    bad   = 0;

    //          wv    wd     rr    fl    co    cnt e  f  o  data
    vecs[0] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1, 0, 0, 8'h00}; // pop on empty
    vecs[1] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1, 0, 0, 0, 8'hA5}; // single push
    vecs[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1, 0, 0, 0, 8'hA5}; // hold
    vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1, 0, 0, 8'h00}; // pop
    vecs[4] = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 1, 0, 0, 0, 8'h33}; // push+pop on empty
    vecs[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1, 0, 0, 0, 8'h33}; // clr_ovf idle
    vecs[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 0, 1, 0, 0, 8'h00}; // flush
    vecs[7] = '{1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 0, 1, 0, 0, 8'h00}; // flush beats push

    do_reset();
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full",  32'(full), 0);
    chk("rst_ovf",   32'(overflow), 0);
    chk("rst_data",  32'(rd_data), 0);

    for (int i = 0; i < 8; i++) begin
      cycle(vecs[i].wv, vecs[i].wd, vecs[i].rr, vecs[i].fl, vecs[i].co, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_tcount", i), 32'(count),    32'(vecs[i].e_count));
      chk($sformatf("vec%0d_tempty", i), 32'(empty),    32'(vecs[i].e_empty));
      chk($sformatf("vec%0d_tfull", i),  32'(full),     32'(vecs[i].e_full));
      chk($sformatf("vec%0d_tovf", i),   32'(overflow), 32'(vecs[i].e_ovf));
      chk($sformatf("vec%0d_tdata", i),  32'(rd_data),  32'(vecs[i].e_data));
    end

    // Fill and wrap: 0x00..0x0F, pop 4, push 0x10..0x13, drain.
    for (int i = 0; i < DEPTH; i++) push(W'(i), "fill");
    chk("fill_full", 32'(full), 1);
    chk("fill_count", 32'(count), 16);
    for (int i = 0; i < 4; i++) pop_expect(W'(i), "wrap_pop");
    for (int i = 0; i < 4; i++) push(W'(16 + i), "wrap_push");
    for (int i = 0; i < DEPTH; i++) pop_expect(W'(4 + i), "wrap_drain");
    chk("wrap_empty", 32'(empty), 1);

    // Overflow: drop into a full FIFO, clear racing a new drop, then clear.
    for (int i = 0; i < DEPTH; i++) push(W'(8'h80 + i), "ovf_fill");
    push(8'hEE, "ovf_drop");
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_count", 32'(count), 16);
    cycle(1'b1, 8'hEF, 1'b0, 1'b0, 1'b1, "ovf_race");
    chk("ovf_race_set", 32'(overflow), 1);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, "ovf_clr");
    chk("ovf_cleared", 32'(overflow), 0);

    // Full with simultaneous push and pop: 0x55 taken, no overflow.
    cycle(1'b1, 8'h55, 1'b1, 1'b0, 1'b0, "full_pp");
    chk("full_pp_count", 32'(count), 16);
    chk("full_pp_ovf", 32'(overflow), 0);
    for (int i = 1; i < DEPTH; i++) pop_expect(W'(8'h80 + i), "full_pp_drain");
    pop_expect(8'h55, "full_pp_last");
    chk("full_pp_empty", 32'(empty), 1);

`ifdef UART_RX_FIFO_IRQ_EN
    // Interrupt threshold and flush.
    irq_en = 1'b1;
    for (int i = 0; i < LVL - 1; i++) push(W'(i), "irq_below");
    chk("irq_below_lvl", 32'(irq), 0);
    push(8'h07, "irq_at");
    chk("irq_at_lvl", 32'(irq), 1);
    chk("irq_at_count", 32'(count), LVL);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, "irq_flush");
    chk("irq_flush_irq", 32'(irq), 0);
    chk("irq_flush_count", 32'(count), 0);
    chk("irq_flush_ovf", 32'(overflow), 0);
`endif

    // Randomized traffic against the queue model.
    for (int n = 0; n < 3000; n++) begin
      logic          wv;
      logic          rr;
      logic          fl;
      logic          co;
      logic [W-1:0]  wd;
      int            bias;
      bias = (n / 500) % 2;
      wv = ($urandom_range(0, 99) < (bias ? 70 : 40));
      rr = ($urandom_range(0, 99) < (bias ? 35 : 60));
      fl = ($urandom_range(0, 199) == 0);
      co = ($urandom_range(0, 29) == 0);
      wd = W'($urandom);
`ifdef UART_RX_FIFO_IRQ_EN
      if ($urandom_range(0, 49) == 0) irq_en = ~irq_en;
`endif
      cycle(wv, wd, rr, fl, co, "rnd");
    end

    // Reset mid-stream discards everything.
    push(8'h11, "pre_rst");
    do_reset();
    check_model("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
